id_ex_pipe: RTL

ID/EX pipeline register with integrated load-use hazard detection for the five-stage RISC-V core. It captures decoded control, operands, immediate and register indices from ID, and presents them to EX and to the forwarding logic. It detects a load followed by a dependent instruction, requests an IF/ID freeze and inserts a bubble. It also supports global memory stall (hold) and branch flush, and keeps saturating bubble/flush counters for performance debug.

---
 rtl/id_ex_pipe.sv | 76 +++++++
 1 files changed

// File: rtl/id_ex_pipe.sv
// id_ex_pipe: ID/EX pipeline register with load-use bubble insertion, stall hold,
// branch flush and saturating bubble/flush counters.
module id_ex_pipe #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              RegWrite_i,
    input  logic              MemtoReg_i,
    input  logic              MemRead_i,
    input  logic              MemWrite_i,
    input  logic              ALUSrc_i,
    input  logic [1:0]        ALUOp_i,
    input  logic [DATA_W-1:0] RS1data_i,
    input  logic [DATA_W-1:0] RS2data_i,
    input  logic [DATA_W-1:0] Imm_i,
    input  logic [9:0]        funct_i,
    input  logic [4:0]        RS1addr_i,
    input  logic [4:0]        RS2addr_i,
    input  logic [4:0]        RDaddr_i,
    output logic              RegWrite_o,
    output logic              MemtoReg_o,
    output logic              MemRead_o,
    output logic              MemWrite_o,
    output logic              ALUSrc_o,
    output logic [1:0]        ALUOp_o,
    output logic [DATA_W-1:0] RS1data_o,
    output logic [DATA_W-1:0] RS2data_o,
    output logic [DATA_W-1:0] Imm_o,
    output logic [9:0]        funct_o,
    output logic [4:0]        RS1addr_o,
    output logic [4:0]        RS2addr_o,
    output logic [4:0]        RDaddr_o,
    output logic              valid_o,
    output logic              hazard_o,
    output logic              PCWrite_o,
    output logic              IF_ID_Write_o,
    output logic [CNT_W-1:0]  bubble_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o
);
    localparam int W = 7 + 3 * DATA_W + 25;

    logic [W-1:0] slot;
    logic         bubble;

    assign {RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o, ALUSrc_o, ALUOp_o,
            RS1data_o, RS2data_o, Imm_o, funct_o, RS1addr_o, RS2addr_o, RDaddr_o} = slot;

    assign hazard_o = valid_o & MemRead_o & (RDaddr_o != 5'd0) &
                      ((RDaddr_o == RS1addr_i) | (RDaddr_o == RS2addr_i));
    assign PCWrite_o     = ~hazard_o;
    assign IF_ID_Write_o = ~hazard_o;
    assign bubble        = flush_i | hazard_o;

    // A bubble clears the whole slot so forwarding sees Rd = x0.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            slot         <= '0;
            valid_o      <= 1'b0;
            bubble_cnt_o <= '0;
            flush_cnt_o  <= '0;
        end else if (!stall_i) begin
            slot    <= bubble ? '0 : {RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i, ALUSrc_i,
                                      ALUOp_i, RS1data_i, RS2data_i, Imm_i, funct_i,
                                      RS1addr_i, RS2addr_i, RDaddr_i};
            valid_o <= ~bubble;
            if (flush_i && !(&flush_cnt_o))
                flush_cnt_o <= flush_cnt_o + CNT_W'(1);
            if (!flush_i && hazard_o && !(&bubble_cnt_o))
                bubble_cnt_o <= bubble_cnt_o + CNT_W'(1);
        end
    end
endmodule
